// File: rtl/fpu_add_arbiter.sv
// rtl/fpu_add_arbiter.sv - round-robin arbiter sharing one pipelined fp32 adder among N requesters
//
// Optional feature macro: FPU_ADD_ARB_SUB_EN (adds req_sub; subtract by flipping operand B sign).
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid[N] / req_ready[N] per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b [32*N]         operands, requester i at [32i+31:32i]
//   req_sub[N]                  (FPU_ADD_ARB_SUB_EN only) issue a-b instead of a+b
//   add_a, add_b, add_in_valid  issue interface to the adder
//   add_result                  adder sum, ADD_LATENCY cycles after add_in_valid
//   rsp_valid, rsp_id, rsp_data one-cycle result strobe routed to the owning requester
//   busy                        any operation in flight
module fpu_add_arbiter #(
  parameter int N           = 4,
  parameter int ADD_LATENCY = 1,
  parameter int IDW         = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
`ifdef FPU_ADD_ARB_SUB_EN
  input  logic [N-1:0]      req_sub,
`endif
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_in_valid,
  input  logic [31:0]       add_result,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              busy
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] nxt_ptr;
  logic [IDW-1:0] issue_id;
  logic [IDW:0]   gsum;
  logic [N-1:0]   rot;
  logic [N-1:0]   gnt;
  logic           found;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           sel_sub;

  // Tag pipeline: one {valid, id} per adder stage; the head lines up with add_result.
  logic [ADD_LATENCY-1:0] tag_v;
  logic [IDW-1:0]         tag_id [ADD_LATENCY];

  // Rotate requests so bit 0 is the requester at the pointer, take the first
  // set bit, then map the rotated position back to a requester id.
  always_comb begin
    rot   = N'({req_valid, req_valid} >> ptr);
    found = 1'b0;
    gsum  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        gsum  = {1'b0, ptr} + (IDW+1)'(k);
      end
    end
    if (gsum >= (IDW+1)'(N)) gsum = gsum - (IDW+1)'(N);
    gnt_id = gsum[IDW-1:0];
  end

  always_comb begin
    gnt     = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (found && (gnt_id == IDW'(i))) begin
        gnt[i] = 1'b1;
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
`ifdef FPU_ADD_ARB_SUB_EN
        sel_sub = req_sub[i];
`endif
      end
    end
  end

  assign req_ready = rst ? '0 : gnt;
  assign nxt_ptr   = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
  assign busy      = add_in_valid | (|tag_v) | rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_in_valid <= 1'b0;
      issue_id     <= '0;
      tag_v        <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_id[k] <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
    end else begin
      add_in_valid <= found;
      if (found) begin
        add_a    <= sel_a;
        // Subtraction only touches the sign of B; zeros and NaNs flip sign too.
        add_b    <= sel_b ^ {sel_sub, 31'd0};
        issue_id <= gnt_id;
        ptr      <= nxt_ptr;
      end
      // Stage 0 loads on the cycle the adder sees add_in_valid.
      tag_v[0]  <= add_in_valid;
      tag_id[0] <= issue_id;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      rsp_valid <= tag_v[ADD_LATENCY-1];
      if (tag_v[ADD_LATENCY-1]) begin
        rsp_id   <= tag_id[ADD_LATENCY-1];
        rsp_data <= add_result;
      end
    end
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb/tb_fpu_add_arbiter.sv - scoreboard bench for fpu_add_arbiter (adder latency 1 and 3)
module tb_fpu_add_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Ideal adder stand-in: test-plan pairs give their IEEE sums, others a fixed asymmetric mix.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'hC0933333, 32'hC0933333}: return 32'hC1133333;
      {32'hC0933333, 32'h3F199999}: return 32'hC0800000;
      {32'h404CCCCC, 32'hBF199999}: return 32'h40266666;
      {32'h404CCCCC, 32'h3F199999}: return 32'h40733333;
      {32'h450A70CC, 32'h4509D199}: return 32'h458A2133;
      default:                      return a + {b[15:0], b[31:16]} + 32'd1;
    endcase
  endfunction

  typedef struct {
    int          t;
    logic [1:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } ent_t;

  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_sub;
  logic [N-1:0]    rdy  [2];
  logic [31:0]     aa   [2];
  logic [31:0]     ab   [2];
  logic            aiv  [2];
  logic            rv   [2];
  logic [1:0]      rid  [2];
  logic [31:0]     rd   [2];
  logic            bsy  [2];
  int              pend [2];

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int LAT = (d == 0) ? 1 : 3;
    logic [31:0] pipe [LAT];
    logic [31:0] res;
    ent_t        iq [$];
    ent_t        sq [$];
    int          mptr = 0;

    always @(posedge clk) begin
      pipe[0] <= fp_model(aa[d], ab[d]);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign res = pipe[LAT-1];

    fpu_add_arbiter #(.N(N), .ADD_LATENCY(LAT)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (rdy[d]),
      .req_a        (req_a),
      .req_b        (req_b),
`ifdef FPU_ADD_ARB_SUB_EN
      .req_sub      (req_sub),
`endif
      .add_a        (aa[d]),
      .add_b        (ab[d]),
      .add_in_valid (aiv[d]),
      .add_result   (res),
      .rsp_valid    (rv[d]),
      .rsp_id       (rid[d]),
      .rsp_data     (rd[d]),
      .busy         (bsy[d])
    );

    always @(negedge clk) begin
      logic [N-1:0] eg;
      logic [N-1:0] xf;
      int           idx;
      ent_t         e;
      if (rst) begin
        iq.delete();
        sq.delete();
        mptr = 0;
      end else begin
        check("busy", bsy[d], sq.size() != 0);
        if (aiv[d]) begin
          if (iq.size() == 0) check("issue_unexpected", aiv[d], 1'b0);
          else begin
            e = iq.pop_front();
            check("issue_latency", cyc, e.t + 1);
            check("add_a", aa[d], e.a);
            check("add_b", ab[d], e.b);
          end
        end
        if (rv[d]) begin
          if (sq.size() == 0) check("rsp_unexpected", rv[d], 1'b0);
          else begin
            e = sq.pop_front();
            check("rsp_latency", cyc, e.t + 2 + LAT);
            check("rsp_id", rid[d], e.id);
            check("rsp_data", rd[d], e.s);
          end
        end
        eg = '0;
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (eg == '0 && req_valid[idx]) eg[idx] = 1'b1;
        end
        check("grant", rdy[d], eg);
        xf = req_valid & rdy[d];
        for (int i = 0; i < N; i++) begin
          if (xf[i]) begin
            e.t  = cyc;
            e.id = 2'(i);
            e.a  = req_a[32*i +: 32];
`ifdef FPU_ADD_ARB_SUB_EN
            e.b  = req_b[32*i +: 32] ^ {req_sub[i], 31'd0};
`else
            e.b  = req_b[32*i +: 32];
`endif
            e.s  = fp_model(e.a, e.b);
            iq.push_back(e);
            sq.push_back(e);
            mptr = (i + 1) % N;
          end
        end
      end
      pend[d] = sq.size();
    end
  end

  // Per-requester stimulus queues {sub, a, b}; the driver holds each item until accepted.
  logic [64:0]  pq [N][$];
  logic [N-1:0] acc;

  initial begin
    logic [64:0] it;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    acc       = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          it = pq[i][0];
          req_valid[i]         = 1'b1;
          req_sub[i]           = it[64];
          req_a[32*i +: 32]    = it[63:32];
          req_b[32*i +: 32]    = it[31:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    acc = req_valid & rdy[0];
  end

  task automatic wait_idle();
    int  w;
    bit  idle;
    w    = 0;
    idle = 1'b0;
    while (!idle && w < 400) begin
      @(posedge clk);
      #2;
      idle = (req_valid == '0) && (pend[0] == 0) && (pend[1] == 0) && !bsy[0] && !bsy[1];
      for (int i = 0; i < N; i++) if (pq[i].size() != 0) idle = 1'b0;
      w++;
    end
    if (!idle) check("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", rdy[d], '0);
      check("rst_add_a", aa[d], '0);
      check("rst_add_b", ab[d], '0);
      check("rst_add_in_valid", aiv[d], 1'b0);
      check("rst_rsp_valid", rv[d], 1'b0);
      check("rst_rsp_id", rid[d], '0);
      check("rst_rsp_data", rd[d], '0);
      check("rst_busy", bsy[d], 1'b0);
    end
  endtask

  initial begin
    int w;
    rst = 1'b1;
    // Single issue request pending during reset: must not be granted until release.
    pq[0].push_back({1'b0, 32'hC0933333, 32'hC0933333});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #3 rst = 1'b0;
    wait_idle();

    // Contention: req1 and req3 together.
    pq[1].push_back({1'b0, 32'hC0933333, 32'h3F199999});
    pq[3].push_back({1'b0, 32'h404CCCCC, 32'hBF199999});
    wait_idle();

    // Fairness: all four requesters valid for 12 transfers.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++)
        pq[i].push_back({1'b0, 32'h1000_0000 * i + 32'(k), 32'h0001_0003 * 32'(k + i)});
    wait_idle();

    // Latency sweep operands.
    pq[2].push_back({1'b0, 32'h450A70CC, 32'h4509D199});
    wait_idle();

    // Subtract request (sign of B flips only with the optional feature built in).
    pq[0].push_back({1'b1, 32'h404CCCCC, 32'h3F199999});
    wait_idle();

    // Random traffic.
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0)
          pq[i].push_back({1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)});
    end
    wait_idle();

    // Reset with operations in flight.
    for (int k = 0; k < 3; k++) pq[1].push_back({1'b0, 32'h3000_0000 + 32'(k), 32'h0000_0100});
    w = 0;
    do begin
      @(posedge clk);
      #2;
      w++;
    end while (!(pq[1].size() == 0 && !req_valid[1]) && w < 50);
    if (w >= 50) check("reset_setup_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #3 rst = 1'b0;
    acc = '0;
    repeat (10) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) pq[i].push_back({1'b0, 32'h2000_0000 + 32'(i), 32'h0000_0005});
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (rdy[0] == '0 && w < 20);
    check("first_grant_after_reset", rdy[0], 4'b0001);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one pipelined 32-bit single-precision FP adder among N requesters.
- Arbitration is round-robin with a valid/ready request handshake.
- Tags each issued operation and routes each adder result back to its requester.
- Sits between the requesting datapath units and the single FPU adder instance.

Parameters:
- N, 4, number of requesters (2..8).
- ADD_LATENCY, 1, adder cycles from add_in_valid to add_result valid (>=1, fixed; the adder never stalls).
- IDW, $clog2(N), width of the requester id.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; one-hot or zero
- req_a  in  32*N  operand A, requester i at bits [32i+31:32i]
- req_b  in  32*N  operand B, same packing
- add_a  out  32  operand A to the adder
- add_b  out  32  operand B to the adder
- add_in_valid  out  1  issue strobe to the adder
- add_result  in  32  adder sum, ADD_LATENCY cycles after issue
- rsp_valid  out  1  result strobe, one cycle
- rsp_id  out  IDW  requester owning rsp_data
- rsp_data  out  32  returned sum
- busy  out  1  any operation in flight

Behaviour:
- Reset: the asynchronous reset forces the following.
  - add_a=0, add_b=0, add_in_valid=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Round-robin pointer=0; tag pipeline cleared.
  - req_ready=0 while rst is high.
- Arbitration (combinational grant):
  - Scan req_valid starting at the pointer, wrapping N-1 -> 0.
  - The first asserted requester i gets req_ready[i]=1.
  - At most one grant per cycle.
  - An accepting requester is never blocked: one issue per cycle at full throughput.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i] in cycle T.
  - Requesters must hold req_valid and data stable until accepted.
  - The arbiter never withdraws a grant while req_valid stays high in that cycle.
- Pointer: after a transfer from i, pointer <= (i+1) mod N. With no transfer it holds.
- Issue:
  - At T+1: add_a/add_b carry the registered operands and add_in_valid=1.
  - Otherwise add_in_valid=0 and add_a/add_b hold their last values.
- Tag pipeline:
  - ADD_LATENCY stages of {valid, id}, shifted every cycle.
  - Stage 0 is loaded at the issue cycle.
  - The head aligns with add_result at T+1+ADD_LATENCY.
- Response:
  - rsp_valid/rsp_id/rsp_data are registered from the head stage and add_result.
  - Total latency: transfer at T -> rsp_valid at T+2+ADD_LATENCY.
  - rsp_valid=0 when the head is invalid; rsp_data/rsp_id then hold.
  - The response has no backpressure; requesters must sample on rsp_valid.
- busy = add_in_valid | any tag-stage valid | rsp_valid.
- Order: results return in issue order. Back-to-back issues yield back-to-back responses.
- Simultaneous requests: all N valid every cycle -> grants cycle 0,1,..,N-1,0,…; each requester gets exactly 1/N of the bandwidth.
- A single requester held valid is granted every cycle, because the pointer wraps past the idle requesters.
- Reset mid-operation:
  - In-flight tags are dropped and no rsp_valid is produced for them.
  - Adder outputs returned after reset are ignored.
- Arithmetic: the block never modifies operand bits, except under the optional feature.

Optional Feature:
- Macro: FPU_ADD_ARB_SUB_EN.
- Defined:
  - Adds port req_sub (in, N), sampled on transfer.
  - When req_sub[i]=1, add_b is issued with bit 31 inverted, so the adder computes a-b.
  - Applies to zeros and NaN sign bits too; no other bits change.
- Undefined: port req_sub is absent and operands pass unmodified.

Test Plan:
- Single issue: ADD_LATENCY=1, req0 a=0xC0933333 (-4.6), b=0xC0933333 -> one-cycle req_ready[0]; add_in_valid at T+1; with an ideal adder model, rsp_valid at T+3, rsp_id=0, rsp_data=0xC1133333 (-9.2).
- Contention: req1 (0xC0933333 + 0x3F199999) and req3 (0x404CCCCC + 0xBF199999) valid in the same cycle, pointer=0 -> req1 granted first, req3 next cycle; responses id 1 data 0xC0800000 (-4.0), then id 3 data 0x40266666 (2.6), consecutive cycles.
- Fairness: all 4 requesters valid for 12 cycles -> grant order 0,1,2,3 repeated 3 times; 12 responses with ids in the same order; busy stays high until the last response.
- Latency sweep: ADD_LATENCY=3, req2 a=0x450A70CC, b=0x4509D199 -> rsp_valid exactly 5 cycles after the transfer, rsp_data=0x458A2133 (4420.15), rsp_id=2.
- Reset mid-flight: issue 3 requests, assert rst for 1 cycle while 2 are in flight -> all outputs zero during reset; no rsp_valid after release; the next grant goes to requester 0.
- FPU_ADD_ARB_SUB_EN: req0 a=0x404CCCCC, b=0x3F199999, req_sub[0]=1 -> add_b=0xBF199999, rsp_data=0x40266666; with the macro undefined the same stimulus (no req_sub) issues b unchanged.
